// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: PC / IF/ID / ID/EXE / EXE/MEM enables, flush and bubble
// for load-use stalls, taken-branch flushes and data-memory waits, plus a stall counter.
module pipe_hazard_ctrl #(
  parameter int ASIZE    = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ASIZE-1:0] id_rs1_addr,
  input  logic [ASIZE-1:0] id_rs2_addr,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [ASIZE-1:0] ex_waddr,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic [1:0]       state,
  output logic [15:0]      stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [3:0] LU_CNT_INIT = (LOAD_LAT > 1) ? 4'(LOAD_LAT - 2) : 4'd0;

  state_t      state_q, state_d;
  state_t      ret_q, ret_d;
  state_t      eval_state;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_q;
  logic        lu, mw;

  assign lu = ex_mem_read && (ex_waddr != '0) &&
              ((ex_waddr == id_rs1_addr) || (id_uses_rs2 && (ex_waddr == id_rs2_addr)));
  assign mw = mem_req && !mem_ready;

  // MEM_WAIT resumes by evaluating the saved state as if it were current.
  assign eval_state = (state_q == MEM_WAIT) ? ret_q : state_q;

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_bubble = 1'b0;
    exmem_en    = 1'b0;
    state_d     = state_q;
    ret_d       = ret_q;
    cnt_d       = cnt_q;
    if (rst) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = RUN;
      ret_d       = RUN;
      cnt_d       = '0;
    end else if (mw) begin
      if (state_q != MEM_WAIT) begin
        ret_d   = state_q;
        state_d = MEM_WAIT;
      end
    end else begin
      case (eval_state)
        LU_STALL: begin
          ifid_flush  = 1'b0;
          idex_en     = 1'b1;
          idex_bubble = 1'b1;
          exmem_en    = 1'b1;
          if (cnt_q == '0) begin
            state_d = RUN;
          end else begin
            cnt_d   = cnt_q - 4'd1;
            state_d = LU_STALL;
          end
        end
        default: begin
          state_d = RUN;
          if (ex_branch_taken) begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            ifid_flush  = 1'b1;
            idex_en     = 1'b1;
            idex_bubble = 1'b1;
            exmem_en    = 1'b1;
          end else if (lu) begin
            idex_en     = 1'b1;
            idex_bubble = 1'b1;
            exmem_en    = 1'b1;
            if (LOAD_LAT > 1) begin
              cnt_d   = LU_CNT_INIT;
              state_d = LU_STALL;
            end
          end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      ret_q   <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      if (!pc_en && (stall_q != '1))
        stall_q <= stall_q + 16'd1;
    end
  end

  assign state        = state_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: two instances (LOAD_LAT=1 and 3) share inputs;
// the driver queues per-cycle expectations and a monitor compares them mid-cycle.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] id_rs1_addr, id_rs2_addr, ex_waddr;
  logic       id_uses_rs2, ex_mem_read, ex_branch_taken, mem_req, mem_ready;

  logic        pc1, ie1, if1, de1, db1, me1;
  logic [1:0]  st1;
  logic [15:0] sc1;
  logic        pc3, ie3, if3, de3, db3, me3;
  logic [1:0]  st3;
  logic [15:0] sc3;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.ASIZE(3), .LOAD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read), .ex_waddr(ex_waddr),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc1), .ifid_en(ie1), .ifid_flush(if1), .idex_en(de1), .idex_bubble(db1),
    .exmem_en(me1), .state(st1), .stall_cycles(sc1));

  pipe_hazard_ctrl #(.ASIZE(3), .LOAD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read), .ex_waddr(ex_waddr),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc3), .ifid_en(ie3), .ifid_flush(if3), .idex_en(de3), .idex_bubble(db3),
    .exmem_en(me3), .state(st3), .stall_cycles(sc3));

  // control vector order: {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en}
  localparam logic [5:0] C_RUN = 6'b110101;
  localparam logic [5:0] C_LU  = 6'b000111;
  localparam logic [5:0] C_BR  = 6'b111111;
  localparam logic [5:0] C_FRZ = 6'b000000;
  localparam logic [5:0] C_RST = 6'b001010;

  typedef struct {
    int         sel;
    logic [5:0] ctl;
    int         st;
    int         stall;
  } exp_t;

  exp_t q[$];
  int   sel = 1;
  int   checks = 0;
  int   fails = 0;

  task automatic idle_in();
    id_rs1_addr = '0; id_rs2_addr = '0; ex_waddr = '0;
    id_uses_rs2 = 1'b0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; rst = 1'b0;
  endtask

  task automatic cyc(input logic [5:0] ctl, input int st, input int stall);
    q.push_back('{sel, ctl, st, stall});
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu(input logic [2:0] a);
    ex_mem_read = 1'b1; ex_waddr = a; id_rs1_addr = a;
  endtask

  initial begin : monitor
    exp_t        e;
    logic [5:0]  act_ctl;
    logic [1:0]  act_st;
    logic [15:0] act_sc;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.sel == 1) begin
          act_ctl = {pc1, ie1, if1, de1, db1, me1}; act_st = st1; act_sc = sc1;
        end else begin
          act_ctl = {pc3, ie3, if3, de3, db3, me3}; act_st = st3; act_sc = sc3;
        end
        checks++;
        if ((act_ctl !== e.ctl) ||
            (e.st >= 0 && act_st !== 2'(e.st)) ||
            (e.stall >= 0 && act_sc !== 16'(e.stall))) begin
          fails++;
          $display("FAIL cycle_check#%0d dut%0d: ctl=%b st=%0d stall=%0d, required ctl=%b st=%0d stall=%0d",
                   checks, e.sel, act_ctl, act_st, act_sc, e.ctl, e.st, e.stall);
        end
      end
    end
  end

  initial begin : driver
    idle_in();
    rst = 1'b1;
    @(posedge clk); #1;

    // reset and LOAD_LAT=1 load-use
    sel = 1;
    idle_in(); rst = 1'b1; cyc(C_RST, -1, -1);
    rst = 1'b1;            cyc(C_RST, 0, 0);
    idle_in();             cyc(C_RUN, 0, 0);
    set_lu(3'd3);          cyc(C_LU, 0, 0);
    idle_in();             cyc(C_RUN, 0, 1);
    set_lu(3'd0);          cyc(C_RUN, 0, 1);
    idle_in();             cyc(C_RUN, 0, 1);
    set_lu(3'd3); ex_branch_taken = 1'b1; cyc(C_BR, 0, 1);
    idle_in();             cyc(C_RUN, 0, 1);

    // LOAD_LAT=3 rs2 match
    sel = 3;
    idle_in(); rst = 1'b1; cyc(C_RST, -1, -1);
    idle_in();             cyc(C_RUN, 0, 0);
    ex_mem_read = 1'b1; ex_waddr = 3'd5; id_rs2_addr = 3'd5; id_uses_rs2 = 1'b1;
    cyc(C_LU, 0, 0);
    idle_in(); ex_branch_taken = 1'b1; cyc(C_LU, 1, 1);
    idle_in();             cyc(C_LU, 1, 2);
    idle_in();             cyc(C_RUN, 0, 3);
    ex_mem_read = 1'b1; ex_waddr = 3'd5; id_rs2_addr = 3'd5; id_uses_rs2 = 1'b0;
    cyc(C_RUN, 0, 3);
    idle_in();             cyc(C_RUN, 0, 3);

    // memory wait inside a load stall
    set_lu(3'd3);          cyc(C_LU, 0, 3);
    idle_in(); mem_req = 1'b1; cyc(C_FRZ, 1, 4);
    cyc(C_FRZ, 2, 5);
    cyc(C_FRZ, 2, 6);
    cyc(C_FRZ, 2, 7);
    mem_ready = 1'b1;      cyc(C_LU, 2, 8);
    idle_in();             cyc(C_LU, 1, 9);
    idle_in();             cyc(C_RUN, 0, 10);

    // memory wait with branch, then same-cycle ready
    mem_req = 1'b1; ex_branch_taken = 1'b1; cyc(C_FRZ, 0, 10);
    cyc(C_FRZ, 2, 11);
    mem_ready = 1'b1;      cyc(C_BR, 2, 12);
    idle_in();             cyc(C_RUN, 0, 12);
    mem_req = 1'b1; mem_ready = 1'b1; cyc(C_RUN, 0, 12);
    idle_in();             cyc(C_RUN, 0, 12);

    // reset aborts MEM_WAIT and LU_STALL
    mem_req = 1'b1;        cyc(C_FRZ, 0, 12);
    cyc(C_FRZ, 2, 13);
    rst = 1'b1;            cyc(C_RST, 2, 14);
    idle_in();             cyc(C_RUN, 0, 0);
    set_lu(3'd2);          cyc(C_LU, 0, 0);
    idle_in(); rst = 1'b1; cyc(C_RST, 1, 1);
    idle_in();             cyc(C_RUN, 0, 0);

    // saturation: 70000 frozen cycles
    mem_req = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk); #1;
    end
    cyc(C_FRZ, 2, 16'hFFFF);
    cyc(C_FRZ, 2, 16'hFFFF);
    idle_in();

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
